freq_meter: RTL and testbench

- Measures the frequency of an asynchronous input, typically a PLL-generated clock or a divided copy of it, by counting its rising edges over a fixed gate window of the system clock.
- Reports one count per window and flags whether the count falls inside an expected range.
- Asserts a lock indication after several consecutive in-range windows.
- Sits beside the clock generator in the arbitrary wave generator as its health/frequency monitor.

---
 rtl/freq_meter_if.sv | 33 +++
 rtl/freq_meter.sv | 178 +++++++++++++++++
 tb/tb_freq_meter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_if.sv
// Measurement-side signal bundle of the frequency meter: run control and
// measured input towards the meter, per-window results back from it.
interface freq_meter_if #(
   parameter int CNT_W = 12
) ();
   logic             enable;
   logic             sig_in;
   logic [CNT_W-1:0] count;
   logic             count_valid;
   logic             overflow;
   logic             in_range;
   logic             locked;

   modport master (
      output enable,
      output sig_in,
      input  count,
      input  count_valid,
      input  overflow,
      input  in_range,
      input  locked
   );

   modport slave (
      input  enable,
      input  sig_in,
      output count,
      output count_valid,
      output overflow,
      output in_range,
      output locked
   );
endinterface

// File: rtl/freq_meter.sv
// Frequency meter: counts synchronized rising edges of sig_in over tiled gate
// windows of GATE_CYCLES clocks, range-checks each count and tracks lock.
module freq_meter #(
   parameter int GATE_CYCLES  = 1200,
   parameter int CNT_W        = 12,
   parameter int SYNC_STAGES  = 2,
   parameter int EXP_MIN      = 95,
   parameter int EXP_MAX      = 105,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic        clk,
   input  logic        rst,
   freq_meter_if.slave bus
);

   localparam int GATE_W = $clog2(GATE_CYCLES);
   localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  RANGE_LO  = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0]  RANGE_HI  = CNT_W'(EXP_MAX);
   localparam logic [LOCK_W-1:0] LOCK_FULL = LOCK_W'(LOCK_WINDOWS);
   localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

   state_t            state_r, state_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic              prev_r;
   logic              edge_s;
   logic [GATE_W-1:0] gate_r, gate_s;
   logic [CNT_W-1:0]  edge_cnt_r, edge_cnt_s;
   logic              ovf_r, ovf_s;
   logic [LOCK_W-1:0] lock_r, lock_s;
   logic [CNT_W-1:0]  sum_s;
   logic              sum_ovf_s;
   logic              range_s;
   logic              report_s;
   logic [CNT_W-1:0]  count_r;
   logic              count_valid_r;
   logic              overflow_r;
   logic              in_range_r;
   logic              locked_r;

   // Input synchronizer and previous-level register for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], bus.sig_in};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;

   // Edge count including this cycle's edge, with saturation and sticky overflow.
   always_comb begin
      sum_s     = edge_cnt_r;
      sum_ovf_s = ovf_r;
      if (edge_s && (edge_cnt_r == CNT_MAX)) begin
         sum_ovf_s = 1'b1;
      end else if (edge_s) begin
         sum_s = edge_cnt_r + CNT_ONE;
      end else begin
         sum_s = edge_cnt_r;
      end
      range_s = !sum_ovf_s && (sum_s >= RANGE_LO) && (sum_s <= RANGE_HI);
   end

   // Next-state logic: window sequencing, abort handling and lock tracking.
   always_comb begin
      state_s    = state_r;
      gate_s     = gate_r;
      edge_cnt_s = edge_cnt_r;
      ovf_s      = ovf_r;
      lock_s     = lock_r;
      report_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            gate_s     = '0;
            edge_cnt_s = '0;
            ovf_s      = 1'b0;
            if (bus.enable) begin
               state_s = ST_MEASURE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            if (gate_r == GATE_LAST) begin
               // Window end reports even if enable just fell; the next window starts at once.
               report_s   = 1'b1;
               gate_s     = '0;
               edge_cnt_s = '0;
               ovf_s      = 1'b0;
               if (range_s) begin
                  lock_s = (lock_r == LOCK_FULL) ? LOCK_FULL : lock_r + LOCK_ONE;
               end else begin
                  lock_s = '0;
               end
               state_s = bus.enable ? ST_MEASURE : ST_IDLE;
            end else if (!bus.enable) begin
               state_s    = ST_IDLE;
               gate_s     = '0;
               edge_cnt_s = '0;
               ovf_s      = 1'b0;
               lock_s     = '0;
            end else begin
               gate_s     = gate_r + GATE_ONE;
               edge_cnt_s = sum_s;
               ovf_s      = sum_ovf_s;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            gate_s     = '0;
            edge_cnt_s = '0;
            ovf_s      = 1'b0;
            lock_s     = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         gate_r     <= '0;
         edge_cnt_r <= '0;
         ovf_r      <= 1'b0;
         lock_r     <= '0;
      end else begin
         state_r    <= state_s;
         gate_r     <= gate_s;
         edge_cnt_r <= edge_cnt_s;
         ovf_r      <= ovf_s;
         lock_r     <= lock_s;
      end
   end

   // Registered result outputs; count/overflow/in_range hold between reports.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r       <= '0;
         count_valid_r <= 1'b0;
         overflow_r    <= 1'b0;
         in_range_r    <= 1'b0;
         locked_r      <= 1'b0;
      end else begin
         count_valid_r <= report_s;
         locked_r      <= (lock_s == LOCK_FULL);
         if (report_s) begin
            count_r    <= sum_s;
            overflow_r <= sum_ovf_s;
            in_range_r <= range_s;
         end else begin
            count_r    <= count_r;
            overflow_r <= overflow_r;
            in_range_r <= in_range_r;
         end
      end
   end

   assign bus.count       = count_r;
   assign bus.count_valid = count_valid_r;
   assign bus.overflow    = overflow_r;
   assign bus.in_range    = in_range_r;
   assign bus.locked      = locked_r;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 12-bit and a 6-bit meter share one stimulus and are
// compared every cycle against a window-level reference model.
module tb_freq_meter;
   localparam int G     = 1200;
   localparam int S     = 2;
   localparam int LOCKW = 4;
   localparam int EMIN  = 95;
   localparam int EMAX  = 105;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic enable = 1'b0;
   logic sig    = 1'b0;

   always #5 clk = ~clk;

   freq_meter_if #(.CNT_W(12)) bus ();
   freq_meter_if #(.CNT_W(6))  bus6 ();

   assign bus.enable  = enable;
   assign bus.sig_in  = sig;
   assign bus6.enable = enable;
   assign bus6.sig_in = sig;

   freq_meter #(.GATE_CYCLES(G), .CNT_W(12), .SYNC_STAGES(S), .EXP_MIN(EMIN),
                .EXP_MAX(EMAX), .LOCK_WINDOWS(LOCKW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   freq_meter #(.GATE_CYCLES(G), .CNT_W(6), .SYNC_STAGES(S), .EXP_MIN(EMIN),
                .EXP_MAX(EMAX), .LOCK_WINDOWS(LOCKW)) dut6 (
      .clk (clk),
      .rst (rst),
      .bus (bus6)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model (window level) ----------------
   int       cyc = 0;
   int       m_ws = 0;
   int       m_n = 0;
   bit       m_act = 1'b0;
   bit [S:0] m_hist = '0;
   int       m_lockc [2];
   bit       e_valid = 1'b0;
   int       e_cnt [2];
   bit       e_ovf [2];
   bit       e_inr [2];
   bit       e_lock [2];

   function automatic int cmax(input int i);
      return (i == 0) ? 4095 : 63;
   endfunction

   task automatic model_update();
      bit ed;
      if (rst) begin
         cyc = 0; m_act = 1'b0; m_n = 0; m_hist = '0; e_valid = 1'b0;
         for (int i = 0; i < 2; i++) begin
            m_lockc[i] = 0; e_cnt[i] = 0; e_ovf[i] = 1'b0; e_inr[i] = 1'b0; e_lock[i] = 1'b0;
         end
      end else begin
         // A rising edge sampled S cycles ago is counted now.
         ed = m_hist[S-1] & ~m_hist[S];
         cyc++;
         e_valid = 1'b0;
         if (m_act) begin
            if (ed) m_n++;
            if (cyc == m_ws + G) begin
               e_valid = 1'b1;
               for (int i = 0; i < 2; i++) begin
                  e_ovf[i] = (m_n > cmax(i));
                  e_cnt[i] = e_ovf[i] ? cmax(i) : m_n;
                  e_inr[i] = !e_ovf[i] && (e_cnt[i] >= EMIN % (cmax(i) + 1))
                                       && (e_cnt[i] <= EMAX % (cmax(i) + 1));
                  m_lockc[i] = e_inr[i] ? ((m_lockc[i] < LOCKW) ? m_lockc[i] + 1 : LOCKW) : 0;
                  e_lock[i] = (m_lockc[i] == LOCKW);
               end
               m_n = 0;
               if (enable) m_ws = cyc;
               else        m_act = 1'b0;
            end else if (!enable) begin
               m_act = 1'b0;
               m_n = 0;
               for (int i = 0; i < 2; i++) begin
                  m_lockc[i] = 0; e_lock[i] = 1'b0;
               end
            end
         end else if (enable) begin
            m_act = 1'b1;
            m_ws = cyc;
            m_n = 0;
         end
         m_hist = {m_hist[S-1:0], sig};
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         model_update();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("outputs12", {16'h0, bus.count_valid, bus.count, bus.overflow, bus.in_range, bus.locked},
                {16'h0, e_valid, 12'(e_cnt[0]), e_ovf[0], e_inr[0], e_lock[0]});
            chk("outputs6", {22'h0, bus6.count_valid, bus6.count, bus6.overflow, bus6.in_range, bus6.locked},
                {22'h0, e_valid, 6'(e_cnt[1]), e_ovf[1], e_inr[1], e_lock[1]});
         end
      end
   end

   // ---------------- stimulus ----------------
   int mode = 0;          // 0 low, 1 square wave, 2 pulse train, 3 random
   int hp = 6;
   int ph = 0;
   int pulses_left = 0;
   int dens = 10;

   task automatic step();
      @(negedge clk);
      case (mode)
         1: begin
            ph++;
            if (ph >= hp) begin sig = ~sig; ph = 0; end
         end
         2: begin
            if (pulses_left > 0) begin
               ph++;
               if (ph >= 4) begin
                  ph = 0;
                  if (sig) begin sig = 1'b0; pulses_left--; end
                  else     sig = 1'b1;
               end
            end
         end
         3: begin
            sig = ($urandom_range(0, 99) < dens);
            if ($urandom_range(0, 1999) == 0) enable = ~enable;
         end
         default: sig = 1'b0;
      endcase
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.count_valid !== 1'b1 && n < 3000);
      if (bus.count_valid !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_valid: no count_valid within %0d cycles, expected one", n);
      end
   endtask

   typedef struct {
      int edges;
      int cnt;
      bit inr;
      bit lck;
   } vec_t;

   vec_t tbl [6];
   int   n;
   int   valids;

   initial begin
      tbl[0] = '{edges: 95,  cnt: 95,  inr: 1'b1, lck: 1'b0};
      tbl[1] = '{edges: 105, cnt: 105, inr: 1'b1, lck: 1'b0};
      tbl[2] = '{edges: 94,  cnt: 94,  inr: 1'b0, lck: 1'b0};
      tbl[3] = '{edges: 106, cnt: 106, inr: 1'b0, lck: 1'b0};
      tbl[4] = '{edges: 0,   cnt: 0,   inr: 1'b0, lck: 1'b0};
      tbl[5] = '{edges: 100, cnt: 100, inr: 1'b1, lck: 1'b0};

      // Reset state
      repeat (3) step();
      chk("reset outputs12", {16'h0, bus.count_valid, bus.count, bus.overflow, bus.in_range, bus.locked}, 32'h0);
      chk("reset outputs6", {22'h0, bus6.count_valid, bus6.count, bus6.overflow, bus6.in_range, bus6.locked}, 32'h0);
      rst = 1'b0;

      // Nominal: toggle every 6 clocks -> 100 edges per window
      enable = 1'b1; mode = 1; hp = 6; ph = 0;
      wait_valid(n);
      chk("first valid latency", n, 1201);
      chk("nominal count", bus.count, 100);
      chk("nominal in_range", bus.in_range, 1);
      chk("nominal overflow", bus.overflow, 0);
      chk("ovf6 count", bus6.count, 63);
      chk("ovf6 overflow", bus6.overflow, 1);
      chk("ovf6 in_range", bus6.in_range, 0);
      chk("locked after 1", bus.locked, 0);
      for (int k = 2; k <= 4; k++) begin
         wait_valid(n);
         chk("window period", n, G);
         chk("nominal count", bus.count, 100);
         chk("locked progression", bus.locked, (k == 4) ? 1 : 0);
      end

      // Out of range: toggle every 5 clocks -> 120 edges
      hp = 5;
      wait_valid(n);
      chk("oor in_range", bus.in_range, 0);
      chk("oor locked drop", bus.locked, 0);
      wait_valid(n);
      chk("oor count", bus.count, 120);
      chk("oor in_range2", bus.in_range, 0);

      // Quiet window, then exact pulse trains for the boundaries
      mode = 0;
      wait_valid(n);
      for (int i = 0; i < 6; i++) begin
         pulses_left = tbl[i].edges; ph = 0; mode = 2;
         wait_valid(n);
         chk("table count", bus.count, tbl[i].cnt);
         chk("table in_range", bus.in_range, tbl[i].inr);
         chk("table locked", bus.locked, tbl[i].lck);
      end

      // Build lock again, then abort mid-window
      mode = 1; hp = 6; ph = 0;
      repeat (3) wait_valid(n);
      chk("relock count", bus.count, 100);
      chk("relock locked", bus.locked, 1);
      repeat (600) step();
      enable = 1'b0;
      valids = 0;
      repeat (1500) begin
         step();
         if (bus.count_valid === 1'b1) valids++;
      end
      chk("abort no valid", valids, 0);
      chk("abort locked", bus.locked, 0);
      chk("abort count hold", bus.count, 100);
      chk("abort in_range hold", bus.in_range, 1);
      enable = 1'b1;
      wait_valid(n);
      chk("reenable latency", n, 1201);
      chk("reenable count", bus.count, 100);

      // Reset mid-window takes effect without a clock edge
      repeat (300) step();
      #2 rst = 1'b1;
      #1;
      chk("async reset12", {16'h0, bus.count_valid, bus.count, bus.overflow, bus.in_range, bus.locked}, 32'h0);
      chk("async reset6", {22'h0, bus6.count_valid, bus6.count, bus6.overflow, bus6.in_range, bus6.locked}, 32'h0);
      step();
      rst = 1'b0;
      wait_valid(n);
      chk("post reset latency", n, 1201);
      chk("post reset in_range", bus.in_range, 1);

      // Randomized: square waves around the range edges, then random levels with enable drops
      for (int r = 0; r < 4; r++) begin
         mode = 1; hp = $urandom_range(5, 7);
         repeat (2500) step();
      end
      for (int r = 0; r < 5; r++) begin
         mode = 3; dens = $urandom_range(2, 60);
         repeat (1500) step();
      end
      mode = 0;
      repeat (10) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
